// File: rtl/image_pipeline_if.sv
// Pixel stream bundle between the pixel source, the image pipeline and the output stage.
// Carries the input pixel/control side and the processed output side with their flags.
// master = source/sink side, slave = the pipeline itself.
interface image_pipeline_if #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 4
);
    logic                    sof;
    logic                    in_valid;
    logic [3*IN_BITS-1:0]    in_rgb;
    logic [7:0]              control;
    logic                    out_valid;
    logic [3*OUT_BITS-1:0]   out_rgb;
    logic                    out_sof;
    logic                    out_eol;
    logic                    out_eof;
    logic                    frame_err;

    modport master (
        output sof, in_valid, in_rgb, control,
        input  out_valid, out_rgb, out_sof, out_eol, out_eof, frame_err
    );

    modport slave (
        input  sof, in_valid, in_rgb, control,
        output out_valid, out_rgb, out_sof, out_eol, out_eof, frame_err
    );
endinterface

// File: rtl/image_pipeline.sv
// Pixel editor: position tracking, ordered dither, grayscale, channel permute/invert, framing check.
// Latency: fixed 3 cycles from in_valid to out_valid (S1 dither, S2 gray, S3 permute/invert).
// Backpressure: none; a pixel is accepted every cycle and bubbles flow through unchanged.
module image_pipeline #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 4,
    parameter int H_SIZE   = 607,
    parameter int V_SIZE   = 455
) (
    input  logic            clk,
    input  logic            reset,
    image_pipeline_if.slave bus
);
    // D = IN_BITS-OUT_BITS is expected to lie in 1..4 so the 4-bit Bayer value can be scaled down.
    localparam int D  = IN_BITS - OUT_BITS;
    localparam int SW = IN_BITS + 1;
    localparam int GW = OUT_BITS + 10;
    // Counters are at least 2 bits wide so x[1:0]/y[1:0] always exist for the Bayer lookup.
    localparam int XW = ($clog2(H_SIZE) > 2) ? $clog2(H_SIZE) : 2;
    localparam int YW = ($clog2(V_SIZE) > 2) ? $clog2(V_SIZE) : 2;
    localparam logic [XW-1:0] X_LAST = XW'(H_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_SIZE - 1);

    typedef enum logic {
        ST_RUN,
        ST_DONE
    } cnt_state_t;

    // S1 payload: truncated/dithered pixel plus the control bits still needed downstream.
    typedef struct packed {
        logic                  vld;
        logic                  sof;
        logic                  eol;
        logic                  eof;
        logic                  gray;
        logic [5:0]            mix;   // [5:3] invert mask, [2:0] permutation
        logic [3*OUT_BITS-1:0] rgb;
    } s1_t;

    // S2 payload: grayscale already applied.
    typedef struct packed {
        logic                  vld;
        logic                  sof;
        logic                  eol;
        logic                  eof;
        logic [5:0]            mix;
        logic [3*OUT_BITS-1:0] rgb;
    } s2_t;

    cnt_state_t state_q, state_d;
    logic [XW-1:0] x_q, x_d, pos_x;
    logic [YW-1:0] y_q, y_d, pos_y;
    logic [7:0]    ctrl_q, ctrl_use;
    logic          err_d;
    logic          flags_ok;
    logic          frame_err_q;
    logic [3:0]    thr;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic [OUT_BITS-1:0] r1, g1, b1;
    logic [GW-1:0]       luma_sum;
    logic [OUT_BITS-1:0] luma;

    logic [OUT_BITS-1:0] r2, g2, b2;
    logic [OUT_BITS-1:0] f_hi, f_mid, f_lo;

    logic                  out_valid_q;
    logic [3*OUT_BITS-1:0] out_rgb_q;
    logic                  out_sof_q, out_eol_q, out_eof_q;

    // 4x4 ordered-dither matrix, indexed by the low two bits of the pixel position.
    function automatic logic [3:0] bayer_at(input logic [1:0] yy, input logic [1:0] xx);
        logic [3:0] b;
        case ({yy, xx})
            4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
            4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
            4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'hA: b = 4'd1;   4'hB: b = 4'd9;
            4'hC: b = 4'd15;  4'hD: b = 4'd7;   4'hE: b = 4'd13;  default: b = 4'd5;
        endcase
        return b;
    endfunction

    // Add the threshold with saturation at full scale, then keep the top OUT_BITS.
    function automatic logic [OUT_BITS-1:0] dither_ch(input logic [IN_BITS-1:0] v,
                                                      input logic [3:0] t,
                                                      input logic en);
        logic [SW-1:0]      sum;
        logic [IN_BITS-1:0] sat;
        sum = {1'b0, v} + (en ? SW'(t) : SW'(0));
        sat = sum[IN_BITS] ? {IN_BITS{1'b1}} : sum[IN_BITS-1:0];
        return OUT_BITS'(sat >> D);
    endfunction

    // Position, framing state and error detection for the pixel currently at the input.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        pos_x    = x_q;
        pos_y    = y_q;
        err_d    = 1'b0;
        flags_ok = 1'b1;
        ctrl_use = ctrl_q;
        if (bus.in_valid) begin
            if (bus.sof) begin
                // A sof anywhere but the expected frame start is a restart and an error.
                ctrl_use = bus.control;
                pos_x    = '0;
                pos_y    = '0;
                if ((state_q == ST_RUN) && ((x_q != '0) || (y_q != '0))) begin
                    err_d = 1'b1;
                end
            end else if (state_q == ST_DONE) begin
                // Extra pixels after the frame end: processed at (0,0) with no flags.
                pos_x    = '0;
                pos_y    = '0;
                err_d    = 1'b1;
                flags_ok = 1'b0;
            end

            if (!bus.sof && (state_q == ST_DONE)) begin
                state_d = ST_DONE;
            end else if (pos_x == X_LAST) begin
                x_d = '0;
                if (pos_y == Y_LAST) begin
                    y_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    y_d     = pos_y + 1'b1;
                    state_d = ST_RUN;
                end
            end else begin
                x_d     = pos_x + 1'b1;
                y_d     = pos_y;
                state_d = ST_RUN;
            end
        end
    end

    // Counter/framing state, frame control latch and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            x_q         <= '0;
            y_q         <= '0;
            ctrl_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (bus.in_valid && bus.sof) begin
                ctrl_q <= bus.control;
            end
            if (err_d) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    // S1 next value: flags from the position and per-channel dither or truncation.
    always_comb begin
        s1_d = '0;
        thr  = bayer_at(pos_y[1:0], pos_x[1:0]) >> (4 - D);
        if (bus.in_valid) begin
            s1_d.vld  = 1'b1;
            s1_d.sof  = flags_ok && (pos_x == '0) && (pos_y == '0);
            s1_d.eol  = flags_ok && (pos_x == X_LAST);
            s1_d.eof  = flags_ok && (pos_x == X_LAST) && (pos_y == Y_LAST);
            s1_d.gray = ctrl_use[1];
            s1_d.mix  = ctrl_use[7:2];
            for (int c = 0; c < 3; c++) begin
                s1_d.rgb[c*OUT_BITS +: OUT_BITS] =
                    dither_ch(bus.in_rgb[c*IN_BITS +: IN_BITS], thr, ctrl_use[0]);
            end
        end
    end

    // S1 pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    assign r1 = s1_q.rgb[3*OUT_BITS-1 -: OUT_BITS];
    assign g1 = s1_q.rgb[2*OUT_BITS-1 -: OUT_BITS];
    assign b1 = s1_q.rgb[OUT_BITS-1 -: OUT_BITS];

    // S2 next value: luma on the reduced channels, replicated into all fields when enabled.
    always_comb begin
        luma_sum = GW'(77) * GW'(r1) + GW'(150) * GW'(g1) + GW'(29) * GW'(b1);
        luma     = OUT_BITS'(luma_sum >> 8);
        s2_d     = '0;
        if (s1_q.vld) begin
            s2_d.vld = 1'b1;
            s2_d.sof = s1_q.sof;
            s2_d.eol = s1_q.eol;
            s2_d.eof = s1_q.eof;
            s2_d.mix = s1_q.mix;
            s2_d.rgb = s1_q.gray ? {3{luma}} : s1_q.rgb;
        end
    end

    // S2 pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_q <= '0;
        end else begin
            s2_q <= s2_d;
        end
    end

    assign r2 = s2_q.rgb[3*OUT_BITS-1 -: OUT_BITS];
    assign g2 = s2_q.rgb[2*OUT_BITS-1 -: OUT_BITS];
    assign b2 = s2_q.rgb[OUT_BITS-1 -: OUT_BITS];

    // S3 channel routing (high, middle, low field) followed by per-field inversion.
    always_comb begin
        case (s2_q.mix[2:0])
            3'd1:    {f_hi, f_mid, f_lo} = {r2, b2, g2};
            3'd2:    {f_hi, f_mid, f_lo} = {g2, r2, b2};
            3'd3:    {f_hi, f_mid, f_lo} = {g2, b2, r2};
            3'd4:    {f_hi, f_mid, f_lo} = {b2, r2, g2};
            3'd5:    {f_hi, f_mid, f_lo} = {b2, g2, r2};
            default: {f_hi, f_mid, f_lo} = {r2, g2, b2};
        endcase
        if (s2_q.mix[5]) f_hi  = ~f_hi;
        if (s2_q.mix[4]) f_mid = ~f_mid;
        if (s2_q.mix[3]) f_lo  = ~f_lo;
    end

    // Output registers; data and flags are forced to zero on bubbles.
    always_ff @(posedge clk) begin
        if (reset || !s2_q.vld) begin
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b1;
            out_rgb_q   <= {f_hi, f_mid, f_lo};
            out_sof_q   <= s2_q.sof;
            out_eol_q   <= s2_q.eol;
            out_eof_q   <= s2_q.eof;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_rgb   = out_rgb_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: doc/image_pipeline.md
# image_pipeline

Parametrised, pipelined successor to the fixed-width pixel editor. It accepts streamed RGB pixels of `IN_BITS` per channel with a valid qualifier and tracks pixel position with internal x/y counters. It applies optional 4x4 ordered (Bayer) dithering, optional grayscale, a channel permutation and per-channel inversion, then emits `OUT_BITS`-per-channel pixels at fixed latency. Control is frame-synchronous, and framing errors are flagged. It sits between the pixel source and the VGA/RGB output stage.

## Interface
- `IN_BITS`, 6: input bits per channel.
- `OUT_BITS`, 4: output bits per channel. The difference `IN_BITS-OUT_BITS` must be 1..4.
- `H_SIZE`, 607: pixels per line.
- `V_SIZE`, 455: lines per frame.

Ports:
- `clk`  in  1  clock. All logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `sof`  in  1  start of frame. Meaningful only when `in_valid`=1; marks that pixel as (0,0).
- `in_valid`  in  1  input pixel valid.
- `in_rgb`  in  3*IN_BITS  {R,G,B}, with R in the MSBs.
- `control`  in  8  [0] dither enable, [1] grayscale, [4:2] permutation, [7:5] invert mask for {R,G,B} output fields.
- `out_valid`  out  1  output pixel valid.
- `out_rgb`  out  3*OUT_BITS  processed pixel.
- `out_sof`  out  1  output pixel is (0,0).
- `out_eol`  out  1  output pixel is last of its line.
- `out_eof`  out  1  output pixel is last of the frame.
- `frame_err`  out  1  sticky framing error flag.

## Operation
- **Control latch:** `ctrl_q` loads `control` when `sof&in_valid`. The sof pixel itself uses the new `control` value, and all other pixels use `ctrl_q`. `ctrl_q` resets to 0, which is full passthrough.
- **Counters:** x and y advance only on `in_valid`.
  - `sof&in_valid` gives that pixel x=0, y=0.
  - x wraps at `H_SIZE-1` to 0 and y increments.
  - After pixel (`H_SIZE-1`, `V_SIZE-1`) the counters enter DONE. Later valid pixels without `sof` use position (0,0) and set `frame_err`.
  - `sof` while not in DONE and not at (0,0) restarts the counters at (0,0) and sets `frame_err`.
  - `sof` with `in_valid`=0 is ignored.
- **Dither**, per channel, with D = `IN_BITS-OUT_BITS`:
  - Threshold t is taken from the Bayer matrix B[y[1:0]][x[1:0]].
  - Matrix rows: y0 = 0,8,2,10; y1 = 12,4,14,6; y2 = 3,11,1,9; y3 = 15,7,13,5.
  - t = B>>(4-D).
  - The channel value plus t saturates at 2^IN_BITS-1, and the top `OUT_BITS` are kept.
  - When dither is disabled, the channel is plain truncation to the top `OUT_BITS`.
- **Grayscale:** Y = (77R+150G+29B)>>8, computed on the `OUT_BITS` values with a full-width intermediate. It is truncated to `OUT_BITS` and replicated to all three fields.
- **Permutation**, output field order high to low:
  - 0 = RGB, 1 = RBG, 2 = GRB, 3 = GBR, 4 = BRG, 5 = BGR.
  - 6 and 7 = RGB.
- **Inversion:** applied after permutation. `ctrl[7]` inverts the high field, `ctrl[6]` the middle field, `ctrl[5]` the low field, each by bitwise NOT.
- **Flags:** `out_sof`, `out_eol` and `out_eof` are computed from the counters at input and delayed with the pixel.
  - Pixels processed in DONE or at error position carry all three flags 0, except a valid `sof` pixel.
  - `frame_err` clears only on reset.

## Timing
- Three register stages:
  - S1: input register, counters, dither/truncate.
  - S2: grayscale.
  - S3: permute/invert, feeding the output registers.
- Latency is exactly 3 cycles from `in_valid` to `out_valid`.
- There is no backpressure. Pixels are accepted every cycle, and bubbles propagate unchanged.
- Data outputs are registered. When `out_valid`=0, `out_rgb` and the flags are 0.
- `frame_err` rises 1 cycle after the offending input cycle.
- Reset values: all outputs 0, pipeline valid bits 0, counters (0,0) not DONE, `ctrl_q`=0.
- Reset asserted mid-stream flushes the pipeline. `out_valid`=0 from the cycle after reset is sampled, and in-flight pixels are discarded.

## Test plan
- **Passthrough:** `control`=0, sof pixel `in_rgb`={45,20,63}. Expect 3 cycles later `out_rgb`={11,5,15}, `out_sof`=1, `out_valid`=1.
- **Dither:** `control`=1, constant R=45, first line.
  - x=0 gives 11, x=1 gives 11 (45+2=47).
  - Second line, x=0 gives 12 (45+3=48).
  - R=63 at (0,1) saturates to 15.
- **Grayscale:** `control`=2, {63,0,0}. Expect {4,4,4}. For {0,63,0} expect {8,8,8}.
- **Permute/invert:**
  - `control`=8'b000_101_00 with {15,5,0} gives {0,5,15}.
  - `control`=8'b100_000_00 gives {0,5,0}.
  - Changing `control` mid-frame has no effect until the next `sof`.
- **Framing:** with H_SIZE=4, V_SIZE=2:
  - 8 valid pixels give `out_eol` on pixels 3 and 7 and `out_eof` on pixel 7, with `frame_err`=0.
  - A 9th pixel without `sof` sets `frame_err`.
  - A fresh `sof` pixel mid-frame sets `frame_err` and gives `out_sof`=1.
- **Reset and bubbles:**
  - `in_valid` toggling 1,0,1 gives `out_valid` 1,0,1 three cycles later.
  - Reset asserted with 2 pixels in flight gives `out_valid`=0 and all outputs 0 the following cycle, and counters restart.
